rob_multi_commit: RTL and testbench
===================================

ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 Parameters SHALL be, one per line:
- ROB_DEPTH, 8, entry count; power of two, 4..64.
- COMMIT_WIDTH, 2, max retirements per cycle; 1..4.
- DATA_W, 64, result width.
- TAG_W, $clog2(ROB_DEPTH), tag width, derived.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a rising clk edge resets the block.
- alloc_valid_i  in  1  dispatch request.
- alloc_ready_o  out  1  entry available.
- alloc_rd_i  in  5  destination register.
- alloc_regwrite_i  in  1  writes register file.
- alloc_isstore_i  in  1  store op.
- alloc_tag_o  out  TAG_W  tag granted (tail index).
- wb_valid_i  in  1  execution result valid.
- wb_tag_i  in  TAG_W  result tag.
- wb_data_i  in  DATA_W  result value.
- wb_mispredict_i  in  1  branch resolved mispredicted.
- wb_target_i  in  64  corrected PC.
- commit_valid_o  out  COMMIT_WIDTH  per-slot retire strobe, slot 0 oldest.
- commit_rd_o  out  COMMIT_WIDTH x 5  per-slot destination.
- commit_data_o  out  COMMIT_WIDTH x DATA_W  per-slot value.
- commit_regwrite_o  out  COMMIT_WIDTH  per-slot register write enable.
- commit_store_o  out  1  slot 0 retires a store.
- flush_o  out  1  pipeline flush pulse.
- flush_target_o  out  64  redirect PC.
- count_o  out  TAG_W+1  occupied entries.

Function
REQ-003 Head/tail pointers SHALL be TAG_W+1 bits; full when indices equal and MSBs differ, empty when equal; wrap modulo ROB_DEPTH.
REQ-004 alloc_ready_o SHALL equal (count_o < ROB_DEPTH) && !flush_o, from registered count only (no same-cycle commit bypass).
REQ-005 On alloc_valid_i && alloc_ready_o an entry SHALL be written at tail with done=0, alloc_tag_o = tail index combinationally, tail+1 next cycle.
REQ-006 On wb_valid_i to an occupied entry: done=1, data, mispredict and target stored; wb to an unoccupied tag SHALL be ignored.
REQ-007 Commit SHALL use registered state only: a wb at edge N is retirable earliest in cycle N+1.
REQ-008 Commit SHALL retire the longest run of consecutive done entries from head, capped at COMMIT_WIDTH and count_o; first not-done entry stops the run.
REQ-009 A store SHALL retire only in slot 0 and ends the group; a store at slot k>0 waits for next cycle.
REQ-010 A mispredicted entry SHALL end the group it retires in; in that cycle flush_o=1 and flush_target_o=its target.
REQ-011 The edge after flush_o SHALL clear all entries, head=tail=0, count_o=0; allocation in the flush cycle is refused (REQ-004).
REQ-012 Simultaneous alloc and commit SHALL update count by (+alloc - retired) in one edge.
REQ-013 Outputs when not asserted: commit_rd_o/commit_data_o don't-care where commit_valid_o=0; flush_target_o=0 when flush_o=0.

Reset
REQ-014 On reset==0 at an edge: head=tail=0, all valid/done=0, count_o=0; next cycle commit_valid_o=0, commit_store_o=0, flush_o=0, alloc_ready_o=1.
REQ-015 Reset mid-operation SHALL discard all entries without retiring or flushing.

Structure
REQ-016 Package rob_pkg SHALL hold the entry struct (valid, done, rd, regwrite, isstore, mispredict, target, data) and width constants.
REQ-017 Combinational group selection SHALL be sub-module rob_commit_select (entries from head in, per-slot retire mask and flush out).

Verification
REQ-018 Reset, then 8 allocs no wb -> tags 0..7, alloc_ready_o=0 after 8th, count_o=8, no commits.
REQ-019 Default params, alloc tags 0..3, wb order 3,1,0,2 -> tags 0,1 retire together one cycle after wb 0 lands, tags 2,3 retire together one cycle after wb 2.
REQ-020 Tags 0..2 done, tag 1 store -> cycle A: slot0 tag 0 only; cycle B: tag 1 with commit_store_o=1; cycle C: tag 2.
REQ-021 Tag 0 done, tag 1 mispredict target 0x40, tags 2..5 done -> tags 0,1 retire, flush_o=1, flush_target_o=0x40, next cycle count_o=0, alloc tag 0.
REQ-022 Full ROB, head done, alloc_valid_i held -> refused that cycle, granted next cycle with wrapped tag 0; reset==0 asserted mid-run -> count_o=0, no commit.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and widths for the multi-commit reorder buffer.
package rob_pkg;
  localparam int MAX_DATA_W = 64;
  localparam int REG_W      = 5;
  localparam int PC_W       = 64;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [REG_W-1:0]      rd;
    logic                  regwrite;
    logic                  isstore;
    logic                  mispredict;
    logic [PC_W-1:0]       target;
    logic [MAX_DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatch / writeback / commit bundle for the reorder buffer.
interface rob_multi_commit_if #(
  parameter int TAG_W        = 3,
  parameter int DATA_W       = 64,
  parameter int COMMIT_WIDTH = 2
);
  logic                              alloc_valid_i;
  logic                              alloc_ready_o;
  logic [4:0]                        alloc_rd_i;
  logic                              alloc_regwrite_i;
  logic                              alloc_isstore_i;
  logic [TAG_W-1:0]                  alloc_tag_o;
  logic                              wb_valid_i;
  logic [TAG_W-1:0]                  wb_tag_i;
  logic [DATA_W-1:0]                 wb_data_i;
  logic                              wb_mispredict_i;
  logic [63:0]                       wb_target_i;
  logic [COMMIT_WIDTH-1:0]           commit_valid_o;
  logic [COMMIT_WIDTH-1:0][4:0]      commit_rd_o;
  logic [COMMIT_WIDTH-1:0][DATA_W-1:0] commit_data_o;
  logic [COMMIT_WIDTH-1:0]           commit_regwrite_o;
  logic                              commit_store_o;
  logic                              flush_o;
  logic [63:0]                       flush_target_o;
  logic [TAG_W:0]                    count_o;

  modport master (
    output alloc_valid_i, alloc_rd_i, alloc_regwrite_i, alloc_isstore_i,
           wb_valid_i, wb_tag_i, wb_data_i, wb_mispredict_i, wb_target_i,
    input  alloc_ready_o, alloc_tag_o, commit_valid_o, commit_rd_o, commit_data_o,
           commit_regwrite_o, commit_store_o, flush_o, flush_target_o, count_o
  );
  modport slave (
    input  alloc_valid_i, alloc_rd_i, alloc_regwrite_i, alloc_isstore_i,
           wb_valid_i, wb_tag_i, wb_data_i, wb_mispredict_i, wb_target_i,
    output alloc_ready_o, alloc_tag_o, commit_valid_o, commit_rd_o, commit_data_o,
           commit_regwrite_o, commit_store_o, flush_o, flush_target_o, count_o
  );
endinterface

// File: rtl/rob_commit_select.sv
// Picks the retire group from the oldest COMMIT_WIDTH entries: a done-prefix,
// with stores only in slot 0 and stores/mispredicts closing the group.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int PTR_W        = 4
) (
  input  rob_entry_t [COMMIT_WIDTH-1:0] win_i,
  input  logic [PTR_W-1:0]              count_i,
  output logic [COMMIT_WIDTH-1:0]       retire_o,
  output logic                          flush_o,
  output logic [PC_W-1:0]               flush_target_o
);
  logic stop;

  always_comb begin
    retire_o       = '0;
    flush_o        = 1'b0;
    flush_target_o = '0;
    stop           = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (!stop && (PTR_W'(k) < count_i) && win_i[k].valid && win_i[k].done &&
          !(win_i[k].isstore && k != 0)) begin
        retire_o[k] = 1'b1;
        if (win_i[k].mispredict) begin
          flush_o        = 1'b1;
          flush_target_o = win_i[k].target;
        end
        stop = win_i[k].isstore | win_i[k].mispredict;
      end else begin
        stop = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rob_multi_commit.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback,
// up to COMMIT_WIDTH in-order retirements per cycle, flush on mispredict.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH    = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int DATA_W       = 64,
  parameter int TAG_W        = $clog2(ROB_DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alloc_valid_i,
  output logic                               alloc_ready_o,
  input  logic [4:0]                         alloc_rd_i,
  input  logic                               alloc_regwrite_i,
  input  logic                               alloc_isstore_i,
  output logic [TAG_W-1:0]                   alloc_tag_o,
  input  logic                               wb_valid_i,
  input  logic [TAG_W-1:0]                   wb_tag_i,
  input  logic [DATA_W-1:0]                  wb_data_i,
  input  logic                               wb_mispredict_i,
  input  logic [63:0]                        wb_target_i,
  output logic [COMMIT_WIDTH-1:0]            commit_valid_o,
  output logic [COMMIT_WIDTH-1:0][4:0]       commit_rd_o,
  output logic [COMMIT_WIDTH-1:0][DATA_W-1:0] commit_data_o,
  output logic [COMMIT_WIDTH-1:0]            commit_regwrite_o,
  output logic                               commit_store_o,
  output logic                               flush_o,
  output logic [63:0]                        flush_target_o,
  output logic [TAG_W:0]                     count_o
);
  localparam int PTR_W = TAG_W + 1;

  rob_entry_t                    ent_q [ROB_DEPTH];
  rob_entry_t                    ent_d [ROB_DEPTH];
  logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]              count, n_ret;
  logic [TAG_W-1:0]              win_idx [COMMIT_WIDTH];
  rob_entry_t [COMMIT_WIDTH-1:0] win;
  logic [COMMIT_WIDTH-1:0]       retire;
  logic                          sel_flush, alloc_fire;
  logic [PC_W-1:0]               sel_target;

  assign count = tail_q - head_q;

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      win_idx[k] = head_q[TAG_W-1:0] + TAG_W'(k);
      win[k]     = ent_q[win_idx[k]];
    end
  end

  rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH), .PTR_W(PTR_W)) u_sel (
    .win_i          (win),
    .count_i        (count),
    .retire_o       (retire),
    .flush_o        (sel_flush),
    .flush_target_o (sel_target)
  );

  // Reset wins over retirement: nothing commits or flushes in a reset cycle.
  assign commit_valid_o = retire & {COMMIT_WIDTH{reset}};
  assign flush_o        = sel_flush & reset;
  assign flush_target_o = flush_o ? sel_target : '0;
  assign commit_store_o = commit_valid_o[0] & win[0].isstore;
  assign alloc_ready_o  = (count < PTR_W'(ROB_DEPTH)) && !flush_o;
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;
  assign alloc_tag_o    = tail_q[TAG_W-1:0];
  assign count_o        = count;

  always_comb begin
    n_ret = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_rd_o[k]       = win[k].rd;
      commit_data_o[k]     = win[k].data[DATA_W-1:0];
      commit_regwrite_o[k] = win[k].regwrite & commit_valid_o[k];
      n_ret                = n_ret + PTR_W'(retire[k]);
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q + n_ret;
    tail_d = tail_q;
    if (wb_valid_i && ent_q[wb_tag_i].valid) begin
      ent_d[wb_tag_i].done       = 1'b1;
      ent_d[wb_tag_i].data       = MAX_DATA_W'(wb_data_i);
      ent_d[wb_tag_i].mispredict = wb_mispredict_i;
      ent_d[wb_tag_i].target     = wb_target_i;
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (retire[k]) begin
        ent_d[win_idx[k]].valid = 1'b0;
        ent_d[win_idx[k]].done  = 1'b0;
      end
    end
    if (alloc_fire) begin
      ent_d[tail_q[TAG_W-1:0]] = '{valid: 1'b1, done: 1'b0, rd: alloc_rd_i,
                                   regwrite: alloc_regwrite_i, isstore: alloc_isstore_i,
                                   mispredict: 1'b0, target: '0, data: '0};
      tail_d = tail_q + 1'b1;
    end
    if (flush_o) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < ROB_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench: a queue-based ROB model predicts each cycle's retire group;
// a negedge monitor compares DUT outputs against the predictions.
module tb_rob_multi_commit;
  localparam int DEPTH = 8;
  localparam int CW    = 2;

  logic clk, reset;
  rob_multi_commit_if #(.TAG_W(3), .DATA_W(64), .COMMIT_WIDTH(CW)) rif ();

  rob_multi_commit #(.ROB_DEPTH(DEPTH), .COMMIT_WIDTH(CW), .DATA_W(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_valid_i     (rif.alloc_valid_i),
    .alloc_ready_o     (rif.alloc_ready_o),
    .alloc_rd_i        (rif.alloc_rd_i),
    .alloc_regwrite_i  (rif.alloc_regwrite_i),
    .alloc_isstore_i   (rif.alloc_isstore_i),
    .alloc_tag_o       (rif.alloc_tag_o),
    .wb_valid_i        (rif.wb_valid_i),
    .wb_tag_i          (rif.wb_tag_i),
    .wb_data_i         (rif.wb_data_i),
    .wb_mispredict_i   (rif.wb_mispredict_i),
    .wb_target_i       (rif.wb_target_i),
    .commit_valid_o    (rif.commit_valid_o),
    .commit_rd_o       (rif.commit_rd_o),
    .commit_data_o     (rif.commit_data_o),
    .commit_regwrite_o (rif.commit_regwrite_o),
    .commit_store_o    (rif.commit_store_o),
    .flush_o           (rif.flush_o),
    .flush_target_o    (rif.flush_target_o),
    .count_o           (rif.count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          rw, st, done, m;
    logic [63:0] data, tgt;
  } ment_t;
  typedef struct {
    int          cnt;
    bit          rdy, fl, st, af;
    int          nret, tag;
    logic [63:0] tgt;
  } cyc_t;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          rw;
  } ret_t;

  ment_t mq[$];
  cyc_t  cq[$];
  ret_t  rq[$];
  int    mtail = 0;
  int    checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: predict outputs from model state, drive inputs, advance the model across the edge.
  task automatic step(input bit rstn, input bit av, input logic [4:0] rd, input bit rw,
                      input bit st, input bit wv, input logic [2:0] wt,
                      input logic [63:0] wd, input bit wm, input logic [63:0] wtg);
    cyc_t c;
    int n = 0;
    bit fl = 0;
    logic [63:0] tg = '0;
    if (rstn) begin
      for (int i = 0; i < CW && i < mq.size(); i++) begin
        if (!mq[i].done || (mq[i].st && i > 0)) break;
        n++;
        if (mq[i].m) begin fl = 1; tg = mq[i].tgt; break; end
        if (mq[i].st) break;
      end
    end
    c.cnt = mq.size(); c.fl = fl; c.tgt = tg; c.nret = n;
    c.st  = (n > 0) && mq[0].st;
    c.rdy = (mq.size() < DEPTH) && !fl;
    c.af  = av && c.rdy;
    c.tag = mtail;
    for (int i = 0; i < n; i++) rq.push_back('{mq[i].rd, mq[i].data, mq[i].rw});
    cq.push_back(c);
    reset = rstn;
    rif.alloc_valid_i = av; rif.alloc_rd_i = rd; rif.alloc_regwrite_i = rw;
    rif.alloc_isstore_i = st; rif.wb_valid_i = wv; rif.wb_tag_i = wt;
    rif.wb_data_i = wd; rif.wb_mispredict_i = wm; rif.wb_target_i = wtg;
    @(posedge clk); #1;
    if (!rstn || fl) begin
      mq.delete();
      mtail = 0;
    end else begin
      if (wv) foreach (mq[i]) if (mq[i].tag == int'(wt)) begin
        mq[i].done = 1; mq[i].data = wd; mq[i].m = wm; mq[i].tgt = wtg;
      end
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (c.af) begin
        mq.push_back('{mtail, rd, rw, st, 1'b0, 1'b0, 64'h0, 64'h0});
        mtail = (mtail + 1) % DEPTH;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alloc(input logic [4:0] rd, input bit st);
    step(1, 1, rd, !st, st, 0, 0, 0, 0, 0);
  endtask
  task automatic wb(input logic [2:0] t, input bit m, input logic [63:0] tg);
    step(1, 0, 0, 0, 0, 1, t, {32'hD00D0000, 29'h0, t}, m, tg);
  endtask

  always @(negedge clk) begin
    cyc_t c;
    ret_t r;
    if (cq.size() > 0) begin
      c = cq.pop_front();
      chk("count", rif.count_o, c.cnt);
      chk("ready", rif.alloc_ready_o, c.rdy);
      chk("cvalid", rif.commit_valid_o, (1 << c.nret) - 1);
      chk("flush", rif.flush_o, c.fl);
      chk("ftarget", rif.flush_target_o, c.tgt);
      chk("store", rif.commit_store_o, c.st);
      if (c.af) chk("tag", rif.alloc_tag_o, c.tag);
      for (int k = 0; k < CW; k++) begin
        if (k < c.nret) begin
          r = rq.pop_front();
          chk("rd", rif.commit_rd_o[k], r.rd);
          chk("data", rif.commit_data_o[k], r.data);
          chk("regwrite", rif.commit_regwrite_o[k], r.rw);
        end else begin
          chk("regwrite_idle", rif.commit_regwrite_o[k], 0);
        end
      end
    end
  end

  initial begin
    bit rn, av, rw, st, wv, wm;
    logic [4:0]  rd;
    logic [2:0]  wt;
    logic [63:0] wd, wtg;
    reset = 0;
    rif.alloc_valid_i = 0; rif.alloc_rd_i = 0; rif.alloc_regwrite_i = 0;
    rif.alloc_isstore_i = 0; rif.wb_valid_i = 0; rif.wb_tag_i = 0;
    rif.wb_data_i = 0; rif.wb_mispredict_i = 0; rif.wb_target_i = 0;
    @(posedge clk); #1;

    // Fill with no writeback: tags 0..7, then refused.
    rst_cyc(1);
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 0);
    idle(2);

    // Out-of-order writeback 3,1,0,2.
    rst_cyc(1);
    for (int i = 0; i < 4; i++) alloc(5'(i + 10), 0);
    wb(3, 0, 0); wb(1, 0, 0); wb(0, 0, 0); idle(1); wb(2, 0, 0); idle(2);

    // Store in the middle splits the group.
    rst_cyc(1);
    alloc(5'd1, 0); alloc(5'd2, 1); alloc(5'd3, 0);
    wb(0, 0, 0); wb(1, 0, 0); wb(2, 0, 0); idle(4);

    // Mispredict at tag 1 flushes younger done entries.
    rst_cyc(1);
    for (int i = 0; i < 6; i++) alloc(5'(i + 20), 0);
    wb(1, 1, 64'h40);
    for (int i = 2; i < 6; i++) wb(3'(i), 0, 0);
    wb(0, 0, 0); idle(1); alloc(5'd7, 0); idle(1);

    // Full ROB with a held allocation, then reset mid-run.
    rst_cyc(1);
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 0);
    wb(0, 0, 0);
    alloc(5'd30, 0); alloc(5'd30, 0);
    wb(1, 0, 0); wb(2, 0, 0);
    rst_cyc(1); idle(2);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rn  = ($urandom % 250) != 0;
      av  = ($urandom % 3) != 0;
      rd  = 5'($urandom);
      st  = ($urandom % 5) == 0;
      rw  = !st && ($urandom % 4 != 0);
      wv  = ($urandom % 4) != 0;
      if (mq.size() > 0 && ($urandom % 5) != 0) wt = 3'(mq[$urandom % mq.size()].tag);
      else wt = 3'($urandom);
      wd  = {$urandom, $urandom};
      wm  = ($urandom % 16) == 0;
      wtg = {$urandom, $urandom};
      step(rn, av, rd, rw, st, wv, wt, wd, wm, wtg);
    end
    idle(4);
    @(negedge clk); @(negedge clk);
    chk("sb_drained", 64'(cq.size() + rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
